// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine spin controller.
// Defaults here are the production settings; modules expose them as parameters.
package slot_pkg;

  localparam int DIGIT_W = 4;
  localparam int CRED_W  = 8;
  localparam int N_REELS = 3;
  localparam int CNT_W   = 8;

  localparam int PULSE_LEN_D  = 4;
  localparam int SETTLE_LEN_D = 2;
  localparam int GAP_LEN_D    = 8;

  localparam logic [CRED_W-1:0]  INIT_CREDITS_D = 8'd20;
  localparam logic [CRED_W-1:0]  BET_D          = 8'd1;
  localparam logic [CRED_W-1:0]  PAY_PAIR_D     = 8'd2;
  localparam logic [CRED_W-1:0]  PAY_TRIPLE_D   = 8'd10;
  localparam logic [CRED_W-1:0]  PAY_JACKPOT_D  = 8'd50;
  localparam logic [DIGIT_W-1:0] BLANK_MIN_D    = 4'd10;
  localparam logic [DIGIT_W-1:0] JACKPOT_DIGIT  = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    SPIN_HI,
    SETTLE,
    CAPTURE,
    GAP,
    EVAL,
    DONE
  } state_t;

endpackage

// File: rtl/slot_payout.sv
// Combinational scorer: maps three captured reels to a payout amount.
// Blank symbols (>= BLANK_MIN) never take part in a match.
module slot_payout
  import slot_pkg::*;
#(
  parameter logic [CRED_W-1:0]  PAY_PAIR    = PAY_PAIR_D,
  parameter logic [CRED_W-1:0]  PAY_TRIPLE  = PAY_TRIPLE_D,
  parameter logic [CRED_W-1:0]  PAY_JACKPOT = PAY_JACKPOT_D,
  parameter logic [DIGIT_W-1:0] BLANK_MIN   = BLANK_MIN_D
) (
  input  logic [N_REELS*DIGIT_W-1:0] reels,
  output logic [CRED_W-1:0]          amount
);

  logic [DIGIT_W-1:0] r0, r1, r2;
  logic               nb0, nb1;
  logic               triple, pair;

  assign r0 = reels[DIGIT_W-1:0];
  assign r1 = reels[2*DIGIT_W-1:DIGIT_W];
  assign r2 = reels[3*DIGIT_W-1:2*DIGIT_W];

  assign nb0 = (r0 < BLANK_MIN);
  assign nb1 = (r1 < BLANK_MIN);

  // A non-blank reel equal to a blank one is impossible, so checking one side suffices.
  assign triple = nb0 && (r0 == r1) && (r1 == r2);
  assign pair   = (nb0 && (r0 == r1)) || (nb0 && (r0 == r2)) || (nb1 && (r1 == r2));

  always_comb begin
    amount = '0;
    if (triple) begin
      amount = (r0 == JACKPOT_DIGIT) ? PAY_JACKPOT : PAY_TRIPLE;
    end else if (pair) begin
      amount = PAY_PAIR;
    end
  end

endmodule

// File: rtl/slot_spin_ctrl.sv
// Drives the rng spin strobe, captures three reels, scores them and keeps a
// saturating credit balance. Start to done is 40 cycles with default timing.
module slot_spin_ctrl
  import slot_pkg::*;
#(
  parameter int                 PULSE_LEN    = PULSE_LEN_D,
  parameter int                 SETTLE_LEN   = SETTLE_LEN_D,
  parameter int                 GAP_LEN      = GAP_LEN_D,
  parameter logic [CRED_W-1:0]  INIT_CREDITS = INIT_CREDITS_D,
  parameter logic [CRED_W-1:0]  BET          = BET_D,
  parameter logic [CRED_W-1:0]  PAY_PAIR     = PAY_PAIR_D,
  parameter logic [CRED_W-1:0]  PAY_TRIPLE   = PAY_TRIPLE_D,
  parameter logic [CRED_W-1:0]  PAY_JACKPOT  = PAY_JACKPOT_D,
  parameter logic [DIGIT_W-1:0] BLANK_MIN    = BLANK_MIN_D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIGIT_W-1:0]         digit,
  output logic                       spin,
  output logic                       busy,
  output logic                       done,
  output logic                       denied,
  output logic [N_REELS*DIGIT_W-1:0] reels,
  output logic [CRED_W-1:0]          payout,
  output logic [CRED_W-1:0]          credits
);

  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_LEN - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(N_REELS - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic [1:0]         idx;
  logic               accept;
  logic [CRED_W-1:0]  amount;
  logic [CRED_W:0]    sum;

  assign cnt_zero = (cnt == '0);
  assign accept   = (state == IDLE) && start && (credits >= BET);
  assign sum      = {1'b0, credits} + {1'b0, amount};

  slot_payout #(
    .PAY_PAIR    (PAY_PAIR),
    .PAY_TRIPLE  (PAY_TRIPLE),
    .PAY_JACKPOT (PAY_JACKPOT),
    .BLANK_MIN   (BLANK_MIN)
  ) u_payout (
    .reels  (reels),
    .amount (amount)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SPIN_HI;
      SPIN_HI: if (cnt_zero) state_nxt = SETTLE;
      SETTLE:  if (cnt_zero) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (idx == LAST_IDX) ? EVAL : GAP;
      GAP:     if (cnt_zero) state_nxt = SPIN_HI;
      EVAL:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // One down-counter serves every timed state; it reloads whenever a new state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      spin    <= 1'b0;
      denied  <= 1'b0;
      reels   <= '0;
      payout  <= '0;
      credits <= INIT_CREDITS;
    end else begin
      if (state_nxt != state) begin
        case (state_nxt)
          SPIN_HI: cnt <= PULSE_LD;
          SETTLE:  cnt <= SETTLE_LD;
          GAP:     cnt <= GAP_LD;
          default: cnt <= '0;
        endcase
      end else if (!cnt_zero) begin
        cnt <= cnt - 1'b1;
      end

      spin   <= (state_nxt == SPIN_HI);
      denied <= (state == IDLE) && start && (credits < BET);

      if (accept) begin
        credits <= credits - BET;
        idx     <= '0;
      end

      if (state == CAPTURE) begin
        for (int i = 0; i < N_REELS; i++) begin
          if (idx == i[1:0]) reels[i*DIGIT_W +: DIGIT_W] <= digit;
        end
        if (idx != LAST_IDX) idx <= idx + 2'd1;
      end

      if (state == EVAL) begin
        payout  <= amount;
        credits <= sum[CRED_W] ? {CRED_W{1'b1}} : sum[CRED_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_slot_spin_ctrl.sv
// Scoreboard bench for slot_spin_ctrl: a scripted rng feeds digits on each spin
// rising edge, expected game results are queued at start and checked at done.
module tb_slot_spin_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        spin, busy, done, denied;
  logic [11:0] reels;
  logic [7:0]  payout, credits;

  slot_spin_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .digit   (digit),
    .spin    (spin),
    .busy    (busy),
    .done    (done),
    .denied  (denied),
    .reels   (reels),
    .payout  (payout),
    .credits (credits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] reels;
    logic [7:0]  pay;
    logic [7:0]  cred;
    int          start_cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] rng_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         mcred = 20;
  int         spin_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // rng model: latches the next scripted digit on the spin rising edge and holds it.
  always @(posedge spin) begin
    if (rng_q.size() > 0) digit = rng_q.pop_front();
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) spin_run = 0;
    else if (spin) spin_run++;
    else if (spin_run != 0) begin
      check("spin_pulse_len", spin_run, 4);
      spin_run = 0;
    end
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) check("done_without_game", int'(done), 0);
      else begin
        e = sb.pop_front();
        check("reels", reels, e.reels);
        check("payout", payout, e.pay);
        check("credits", credits, e.cred);
        check("latency", cyc - e.start_cyc + 1, 40);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mcred = 20;
    rng_q.delete();
    sb.delete();
  endtask

  task automatic start_game(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input int pay);
    exp_t x;
    rng_q.push_back(d0);
    rng_q.push_back(d1);
    rng_q.push_back(d2);
    @(negedge clk);
    mcred = mcred - 1 + pay;
    if (mcred > 255) mcred = 255;
    x.reels = {d2, d1, d0};
    x.pay = 8'(pay);
    x.cred = 8'(mcred);
    x.start_cyc = cyc;
    sb.push_back(x);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    int t;
    n = done_cnt;
    t = 0;
    while (done_cnt == n && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("game_completed", (done_cnt > n) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic play(input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2, input int pay);
    start_game(d0, d1, d2, pay);
    wait_done();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;

    // Reset state
    do_reset();
    check("rst_spin", spin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_denied", denied, 0);
    check("rst_reels", reels, 0);
    check("rst_payout", payout, 0);
    check("rst_credits", credits, 20);

    // Losing spin
    play(4'd3, 4'd5, 4'd9, 0);

    // Winning patterns from a fresh balance
    do_reset();
    play(4'd7, 4'd7, 4'd7, 50);
    check("credits_after_jackpot", credits, 69);
    play(4'd4, 4'd4, 4'd4, 10);
    play(4'd2, 4'd8, 4'd2, 2);

    // Blanks never match
    play(4'd12, 4'd12, 4'd12, 0);
    play(4'd12, 4'd12, 4'd6, 0);

    // Climb to 250, then a jackpot must saturate at 255
    do_reset();
    while (mcred + 49 <= 250) play(4'd7, 4'd7, 4'd7, 50);
    while (mcred + 9 <= 250) play(4'd1, 4'd1, 4'd1, 10);
    while (mcred < 250) play(4'd5, 4'd0, 4'd5, 2);
    check("balance_250", credits, 250);
    play(4'd7, 4'd7, 4'd7, 50);
    check("saturated", credits, 255);

    // Drain to zero, then a start must be refused
    do_reset();
    repeat (20) play(4'd3, 4'd5, 4'd9, 0);
    check("drained", credits, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("denied_pulse", denied, 1);
    check("denied_busy", busy, 0);
    check("denied_credits", credits, 0);
    @(negedge clk);
    check("denied_one_cycle", denied, 0);
    check("denied_still_idle", busy, 0);

    // start during SETTLE and DONE is ignored
    do_reset();
    n0 = done_cnt;
    start_game(4'd3, 4'd5, 4'd9, 0);
    repeat (4) @(negedge clk);
    check("in_settle_spin", spin, 0);
    check("in_settle_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (33) @(negedge clk);
    check("in_done", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("after_done_idle", busy, 0);
    @(negedge clk);
    check("no_queued_game", busy, 0);
    repeat (45) @(negedge clk);
    check("single_game", done_cnt - n0, 1);
    check("single_bet", credits, 19);

    // Reset in GAP after reel0 aborts without refund, then restores defaults
    do_reset();
    rng_q.push_back(4'd3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("gap_reel0", reels, 12'h003);
    check("gap_spin", spin, 0);
    check("gap_busy", busy, 1);
    check("gap_credits", credits, 19);
    rst = 1'b1;
    @(negedge clk);
    check("abort_spin", spin, 0);
    check("abort_busy", busy, 0);
    check("abort_credits", credits, 20);
    check("abort_reels", reels, 0);
    check("abort_payout", payout, 0);
    rst = 1'b0;
    rng_q.delete();
    mcred = 20;
    repeat (5) @(negedge clk);
    check("abort_no_done", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
